// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
package pipe_pkg;

    localparam int XZR = 31;

    typedef struct packed {
        logic       valid;
        logic [4:0] aw;
        logic       regwrite;
        logic       load;
    } sb_entry_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10,
        FWD_RET   = 2'b11
    } fwd_sel_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // An entry only produces a value worth forwarding if it really writes a non-zero register.
    function automatic logic sb_live(sb_entry_t e, logic [4:0] zr);
        return e.valid && e.regwrite && (e.aw != zr);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// Per-operand forwarding select: youngest live producer among MEM, WB and RET wins.
module fwd_match
    import pipe_pkg::*;
#(
    parameter int ZR = XZR
) (
    input  logic [4:0] src,
    input  logic       use_src,
    input  sb_entry_t  mem,
    input  sb_entry_t  wb,
    input  sb_entry_t  ret,
    output fwd_sel_t   sel
);

    localparam logic [4:0] ZR_A = 5'(ZR);

    logic unused_load;
    assign unused_load = mem.load ^ wb.load ^ ret.load;

    always_comb begin
        sel = FWD_RF;
        if (use_src && (src != ZR_A)) begin
            if (sb_live(mem, ZR_A) && (mem.aw == src)) begin
                sel = FWD_EXMEM;
            end else if (sb_live(wb, ZR_A) && (wb.aw == src)) begin
                sel = FWD_MEMWB;
            end else if (sb_live(ret, ZR_A) && (ret.aw == src)) begin
                sel = FWD_RET;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: destination scoreboard for EX/MEM/WB/RET,
// load-use stall sequencing and taken-branch flush.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int LOAD_STALL = 1,
    parameter int ZR         = XZR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_Aa,
    input  logic [4:0] id_Ab,
    input  logic       id_use_a,
    input  logic       id_use_b,
    input  logic [4:0] id_Aw,
    input  logic       id_RegWrite,
    input  logic       id_load,
    input  logic       ex_br_taken,
    input  logic       hold,
    output logic       pc_stall,
    output logic       ex_bubble,
    output logic       flush_ifid,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    localparam logic [4:0] ZR_A       = 5'(ZR);
    localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL - 1);

    sb_entry_t  ex_e, mem_e, wb_e, ret_e;
    sb_entry_t  id_e;
    logic [4:0] ex_aa, ex_ab;
    logic       ex_use_a, ex_use_b;
    logic [1:0] stall_cnt, stall_cnt_nxt;
    logic       load_use, stall_req, squash;
    fwd_sel_t   sel_a, sel_b;

    always_comb begin
        id_e          = SB_EMPTY;
        id_e.valid    = id_valid;
        id_e.aw       = id_Aw;
        id_e.regwrite = id_RegWrite;
        id_e.load     = id_load;

        load_use  = id_valid && sb_live(ex_e, ZR_A) && ex_e.load &&
                    ((id_use_a && (id_Aa == ex_e.aw)) || (id_use_b && (id_Ab == ex_e.aw)));
        stall_req = load_use || (stall_cnt != 2'd0);
        squash    = ex_br_taken || stall_req;

        // A taken branch kills any pending load-use stall outright.
        stall_cnt_nxt = 2'd0;
        if (ex_br_taken) begin
            stall_cnt_nxt = 2'd0;
        end else if (stall_cnt != 2'd0) begin
            stall_cnt_nxt = stall_cnt - 2'd1;
        end else if (load_use) begin
            stall_cnt_nxt = STALL_INIT;
        end

        pc_stall   = !reset && (hold || (!ex_br_taken && stall_req));
        ex_bubble  = !reset && !hold && squash;
        flush_ifid = !reset && !hold && ex_br_taken;
        fwd_a      = reset ? 2'b00 : sel_a;
        fwd_b      = reset ? 2'b00 : sel_b;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_e      <= SB_EMPTY;
            mem_e     <= SB_EMPTY;
            wb_e      <= SB_EMPTY;
            ret_e     <= SB_EMPTY;
            ex_aa     <= 5'd0;
            ex_ab     <= 5'd0;
            ex_use_a  <= 1'b0;
            ex_use_b  <= 1'b0;
            stall_cnt <= 2'd0;
        end else if (!hold) begin
            ret_e     <= wb_e;
            wb_e      <= mem_e;
            mem_e     <= ex_e;
            ex_e      <= squash ? SB_EMPTY : id_e;
            ex_aa     <= squash ? 5'd0 : id_Aa;
            ex_ab     <= squash ? 5'd0 : id_Ab;
            ex_use_a  <= !squash && id_use_a;
            ex_use_b  <= !squash && id_use_b;
            stall_cnt <= stall_cnt_nxt;
        end
    end

    fwd_match #(.ZR(ZR)) u_fwd_a (
        .src     (ex_aa),
        .use_src (ex_use_a),
        .mem     (mem_e),
        .wb      (wb_e),
        .ret     (ret_e),
        .sel     (sel_a)
    );

    fwd_match #(.ZR(ZR)) u_fwd_b (
        .src     (ex_ab),
        .use_src (ex_use_b),
        .mem     (mem_e),
        .wb      (wb_e),
        .ret     (ret_e),
        .sel     (sel_b)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LOAD_STALL 1 and 3) share stimulus and
// are compared every cycle against an instruction-history model, plus literal spot checks.
module tb_pipe_hazard_ctrl;

    localparam int ZRB = 31;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_a, id_use_b, id_RegWrite, id_load;
    logic [4:0] id_Aa, id_Ab, id_Aw;
    logic       ex_br_taken, hold;
    logic [1:0] pcs, bub, fl;
    logic [1:0] fa [2];
    logic [1:0] fb [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_STALL(1)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_Aa(id_Aa), .id_Ab(id_Ab),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_Aw(id_Aw), .id_RegWrite(id_RegWrite),
        .id_load(id_load), .ex_br_taken(ex_br_taken), .hold(hold),
        .pc_stall(pcs[0]), .ex_bubble(bub[0]), .flush_ifid(fl[0]), .fwd_a(fa[0]), .fwd_b(fb[0])
    );

    pipe_hazard_ctrl #(.LOAD_STALL(3)) dut3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_Aa(id_Aa), .id_Ab(id_Ab),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_Aw(id_Aw), .id_RegWrite(id_RegWrite),
        .id_load(id_load), .ex_br_taken(ex_br_taken), .hold(hold),
        .pc_stall(pcs[1]), .ex_bubble(bub[1]), .flush_ifid(fl[1]), .fwd_a(fa[1]), .fwd_b(fb[1])
    );

    // Model: per instance, history of the last four instructions to leave ID.
    // Age 0 is EX; a producer at age d forwards to EX with select code d.
    bit mh_wr [2][4];
    int mh_rd [2][4];
    bit mh_ld [2][4];
    int msa [2];
    int msb [2];
    int owed [2];

    function automatic int ls_of(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit m_lu(int k);
        return id_valid && mh_wr[k][0] && mh_ld[k][0] &&
               ((id_use_a && int'(id_Aa) == mh_rd[k][0]) || (id_use_b && int'(id_Ab) == mh_rd[k][0]));
    endfunction

    function automatic int m_fwd(int k, int src);
        if (src < 0 || src == ZRB) return 0;
        for (int d = 1; d <= 3; d++)
            if (mh_wr[k][d] && mh_rd[k][d] == src) return d;
        return 0;
    endfunction

    function automatic int e_stall(int k);
        return (m_lu(k) || owed[k] > 0) ? 1 : 0;
    endfunction

    function automatic int e_pcs(int k);
        if (reset) return 0;
        if (hold) return 1;
        if (ex_br_taken) return 0;
        return e_stall(k);
    endfunction

    function automatic int e_bub(int k);
        if (reset || hold) return 0;
        if (ex_br_taken) return 1;
        return e_stall(k);
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int d = 0; d < 4; d++) begin
                    mh_wr[k][d] <= 1'b0;
                    mh_rd[k][d] <= 0;
                    mh_ld[k][d] <= 1'b0;
                end
                msa[k]  <= -1;
                msb[k]  <= -1;
                owed[k] <= 0;
            end else if (!hold) begin
                for (int d = 1; d < 4; d++) begin
                    mh_wr[k][d] <= mh_wr[k][d-1];
                    mh_rd[k][d] <= mh_rd[k][d-1];
                    mh_ld[k][d] <= mh_ld[k][d-1];
                end
                if (ex_br_taken || e_stall(k) == 1) begin
                    mh_wr[k][0] <= 1'b0;
                    mh_rd[k][0] <= 0;
                    mh_ld[k][0] <= 1'b0;
                    msa[k] <= -1;
                    msb[k] <= -1;
                end else begin
                    mh_wr[k][0] <= id_valid && id_RegWrite && int'(id_Aw) != ZRB;
                    mh_rd[k][0] <= int'(id_Aw);
                    mh_ld[k][0] <= id_load;
                    msa[k] <= id_use_a ? int'(id_Aa) : -1;
                    msb[k] <= id_use_b ? int'(id_Ab) : -1;
                end
                if (ex_br_taken)      owed[k] <= 0;
                else if (owed[k] > 0) owed[k] <= owed[k] - 1;
                else if (m_lu(k))     owed[k] <= ls_of(k) - 1;
                else                  owed[k] <= 0;
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("cyc_pc_stall[%0d]", k), int'(pcs[k]), e_pcs(k));
            check($sformatf("cyc_ex_bubble[%0d]", k), int'(bub[k]), e_bub(k));
            check($sformatf("cyc_flush[%0d]", k), int'(fl[k]), (!reset && !hold && ex_br_taken) ? 1 : 0);
            check($sformatf("cyc_fwd_a[%0d]", k), int'(fa[k]), reset ? 0 : m_fwd(k, msa[k]));
            check($sformatf("cyc_fwd_b[%0d]", k), int'(fb[k]), reset ? 0 : m_fwd(k, msb[k]));
        end
    end

    task automatic set_id(input logic v, input int aa, input logic ua, input int ab, input logic ub,
                          input int aw, input logic rw, input logic ld);
        id_valid    = v;
        id_Aa       = 5'(aa);
        id_use_a    = ua;
        id_Ab       = 5'(ab);
        id_use_b    = ub;
        id_Aw       = 5'(aw);
        id_RegWrite = rw;
        id_load     = ld;
    endtask

    task automatic nop();
        set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        #3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ex_br_taken = 1'b0;
        hold = 1'b0;
        nop();
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc_stall", int'(pcs[0]), 0);
        check("reset_fwd_a", int'(fa[1]), 0);
        reset = 1'b0;

        // Producer/consumer distance 1..4
        for (int d = 1; d <= 4; d++) begin
            set_id(1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b1, 1'b0);
            tick();
            repeat (d - 1) begin nop(); tick(); end
            set_id(1'b1, 1, 1'b1, 3, 1'b1, 2, 1'b0, 1'b0);
            tick();
            nop();
            peek();
            check($sformatf("dist%0d_fwd_a_ls1", d), int'(fa[0]), (d < 4) ? d : 0);
            check($sformatf("dist%0d_fwd_a_ls3", d), int'(fa[1]), (d < 4) ? d : 0);
            check($sformatf("dist%0d_fwd_b", d), int'(fb[0]), 0);
            repeat (4) tick();
        end

        // Load-use: LDUR X5 ; ADD X6,X5,X7 held in ID
        set_id(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5, 1'b1, 7, 1'b1, 6, 1'b1, 1'b0);
        peek();
        check("lu_c0_pc_stall_ls1", int'(pcs[0]), 1);
        check("lu_c0_bubble_ls1", int'(bub[0]), 1);
        check("lu_c0_pc_stall_ls3", int'(pcs[1]), 1);
        tick(); peek();
        check("lu_c1_pc_stall_ls1", int'(pcs[0]), 0);
        check("lu_c1_pc_stall_ls3", int'(pcs[1]), 1);
        tick(); peek();
        check("lu_c2_fwd_a_ls1", int'(fa[0]), 2);
        check("lu_c2_pc_stall_ls3", int'(pcs[1]), 1);
        tick(); peek();
        check("lu_c3_pc_stall_ls3", int'(pcs[1]), 0);
        tick(); peek();
        check("lu_c4_fwd_a_ls3", int'(fa[1]), 0);
        nop();
        repeat (4) tick();

        // Zero register and unused operand
        set_id(1'b1, 0, 1'b0, 0, 1'b0, 31, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 31, 1'b1, 31, 1'b1, 4, 1'b1, 1'b0);
        peek();
        check("zr_pc_stall", int'(pcs[0]), 0);
        check("zr_pc_stall_ls3", int'(pcs[1]), 0);
        tick(); nop(); peek();
        check("zr_fwd_a", int'(fa[0]), 0);
        check("zr_fwd_b", int'(fb[0]), 0);
        repeat (4) tick();
        set_id(1'b1, 0, 1'b0, 0, 1'b0, 8, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 0, 1'b1, 8, 1'b0, 4, 1'b1, 1'b0);
        peek();
        check("unused_b_pc_stall", int'(pcs[0]), 0);
        check("unused_b_bubble", int'(bub[1]), 0);
        nop();
        repeat (4) tick();

        // Taken branch in the same cycle as a load-use detect
        set_id(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 9, 1'b1, 0, 1'b0, 4, 1'b1, 1'b0);
        ex_br_taken = 1'b1;
        peek();
        check("br_flush", int'(fl[0]), 1);
        check("br_bubble", int'(bub[0]), 1);
        check("br_pc_stall", int'(pcs[0]), 0);
        check("br_pc_stall_ls3", int'(pcs[1]), 0);
        tick();
        ex_br_taken = 1'b0;
        peek();
        check("br_after_pc_stall_ls3", int'(pcs[1]), 0);
        check("br_after_bubble_ls3", int'(bub[1]), 0);
        nop();
        repeat (4) tick();

        // Hold freezes scoreboard and forwarding
        set_id(1'b1, 0, 1'b0, 0, 1'b0, 10, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 10, 1'b1, 0, 1'b0, 11, 1'b1, 1'b0);
        tick();
        nop();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            peek();
            check($sformatf("hold%0d_fwd_a", i), int'(fa[0]), 1);
            check($sformatf("hold%0d_pc_stall", i), int'(pcs[0]), 1);
            check($sformatf("hold%0d_bubble", i), int'(bub[0]), 0);
            tick();
        end
        hold = 1'b0;
        set_id(1'b1, 10, 1'b1, 0, 1'b0, 12, 1'b0, 1'b0);
        tick();
        nop();
        peek();
        check("hold_resume_fwd_a", int'(fa[0]), 2);
        repeat (4) tick();

        // Asynchronous reset during a LOAD_STALL=3 stall
        set_id(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0);
        peek();
        check("rst_pre_pc_stall_ls3", int'(pcs[1]), 1);
        tick();
        #2 reset = 1'b1;
        #1;
        check("rst_async_pc_stall", int'(pcs[1]), 0);
        check("rst_async_bubble", int'(bub[1]), 0);
        check("rst_async_flush", int'(fl[1]), 0);
        check("rst_async_fwd_a", int'(fa[1]), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        peek();
        check("rst_post_pc_stall", int'(pcs[1]), 0);
        tick();
        nop();
        peek();
        check("rst_post_fwd_a_ls3", int'(fa[1]), 0);
        check("rst_post_fwd_a_ls1", int'(fa[0]), 0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipelined ARM core (IF, ID, EX, MEM, WB) built around the shared regfile, ALU and datamem datapath.
- Keeps its own scoreboard of destination registers for the instructions in EX, MEM, WB and one retired stage.
- From that scoreboard it produces forwarding selects for the ALU operands, load-use stall/bubble control, and flush control on taken branches.

Parameters:
- LOAD_STALL, default 1: stall cycles inserted on a load-use hazard (1..3).
- ZR, default 31: register index that is never a hazard (XZR).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_Aa  in  5  ID read register 1 (Rn)
- id_Ab  in  5  ID read register 2 (Rd or Rm, after Reg2Loc)
- id_use_a, id_use_b  in  1 each  ID instruction actually reads Aa / Ab
- id_Aw  in  5  ID write register (Rd or X30, after Rd_X30)
- id_RegWrite  in  1  ID instruction writes the regfile
- id_load  in  1  ID instruction is LDUR (MemToReg)
- ex_br_taken  in  1  branch resolved taken in EX this cycle
- hold  in  1  global freeze (memory not ready)
- pc_stall  out  1  hold PC and the IF/ID register
- ex_bubble  out  1  load NOP into ID/EX
- flush_ifid  out  1  clear IF/ID
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB Dw, 11 retired-write register

Behaviour:
- Reset values (asynchronous): every scoreboard entry invalid, stall counter 0, EX source registers 0. All outputs read 0 while reset is asserted.
- Scoreboard entry: {valid, Aw, RegWrite, load}. Stages are EX, MEM, WB, RET. An entry is live only when valid=1, RegWrite=1 and Aw≠ZR.
- Advance on each rising edge when hold=0:
  - RET<=WB, WB<=MEM, MEM<=EX.
  - EX<=ID entry, or an invalid entry when ex_bubble=1 or ex_br_taken=1.
  - EX source regs (ex_Aa, ex_Ab, ex_use_*) load from ID at the same edge, or clear to not-used on bubble/flush.
- hold=1: all state frozen. pc_stall=1, ex_bubble=0, flush_ifid=0.
- Forwarding (combinational from registered state), for each operand X in {a, b} with use=1:
  - MEM entry live and Aw==ex_AX -> 01;
  - else WB match -> 10;
  - else RET match -> 11;
  - else 00.
  - Youngest producer wins. use=0 or source==ZR -> 00.
- Load-use detect: id_valid and EX entry live with load=1 and (id_use_a and id_Aa==EX.Aw, or id_use_b and id_Ab==EX.Aw).
  - On detect: pc_stall=1 and ex_bubble=1 this cycle.
  - Stall counter loads LOAD_STALL-1. While the counter is nonzero, pc_stall=ex_bubble=1 and the counter decrements per unheld cycle.
  - LOAD_STALL=1 gives exactly one bubble.
- Taken branch (ex_br_taken=1, hold=0):
  - flush_ifid=1 and ex_bubble=1, so the two younger instructions are squashed.
  - pc_stall=0, so the PC takes the branch target.
  - Stall counter cleared; branch overrides any pending load-use stall.
- id_valid=0: no hazard detected. The ID entry still shifts into EX as invalid.
- reset mid-stall or mid-flush: everything returns to reset state immediately. No residual bubbles.

Decomposition:
- Shared package pipe_pkg:
  - typedef sb_entry_t {valid, aw[4:0], regwrite, load};
  - enum fwd_sel_t {FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_RET=2'b11};
  - localparam XZR=31.
- Sub-module fwd_match: one live-entry/address comparator with priority encode. Instantiate it once per operand (a, b).

Test Plan:
1. Producer/consumer distance:
   - ADDS X1,.. then ADD X2,X1,X3 back-to-back -> in the consumer's EX cycle fwd_a=01.
   - Distance 2 -> fwd_a=10; distance 3 -> fwd_a=11; distance 4 -> 00.
2. Load-use, LOAD_STALL=1:
   - LDUR X5 followed by ADD X6,X5,X7 -> one cycle with pc_stall=1 and ex_bubble=1.
   - Next cycle the ADD enters EX with fwd_a=10.
   - With LOAD_STALL=3 -> three stall cycles.
3. Zero register and unused operand:
   - LDUR X31 then a reader of X31 -> no stall, fwd=00.
   - Reader with id_use_b=0 and a matching Ab -> no stall.
4. Branch during stall:
   - ex_br_taken=1 in the same cycle a load-use is detected -> flush_ifid=1, ex_bubble=1, pc_stall=0.
   - Stall counter 0 the following cycle.
5. Hold:
   - hold=1 for 3 cycles mid-sequence -> scoreboard and fwd outputs unchanged, pc_stall=1.
   - Resumes with correct forwarding after hold drops.
6. Reset:
   - Assert reset asynchronously (between edges) during a LOAD_STALL=3 stall -> all outputs 0 immediately, without waiting for a clock edge.
   - After release, the first consumer sees fwd=00.
